imem_loader: RTL and testbench

Boot-time program loader and fetch gate for the instruction ROM. It accepts a byte stream (UART/JTAG bridge side), assembles little-endian 32-bit words, and writes them through the ROM programming port (`prog_en`/`prog_addr`/`prog_data`). While a load is in progress or has not yet completed, it holds the core and blocks fetch reads. When the load finishes it releases the core.

---
 rtl/imem_loader.sv | 138 +++++++++++++
 tb/tb_imem_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction ROM with fetch gating
module imem_loader #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ROM_SIZE  = 8192,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            byte_ready,
  output logic            prog_en,
  output logic [XLEN-1:0] prog_addr,
  output logic [XLEN-1:0] prog_data,
  input  logic            fetch_ren_in,
  output logic            fetch_ren_out,
  output logic            core_hold,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [15:0]     words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] CAPACITY  = 32'(ROM_SIZE / 4);
  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

  state_t      state, state_nx;
  logic [1:0]  byte_idx, byte_idx_nx;
  logic [31:0] word_cnt, word_cnt_nx;
  logic [31:0] word_sr, word_sr_nx;
  logic [31:0] wd_cnt, wd_nx;
  logic [15:0] words_nx;
  logic [15:0] words_inc;
  logic [31:0] shifted_cnt;
  logic [31:0] shifted_sr;
  logic [31:0] wd_inc;
  logic        xfer;

  assign xfer        = byte_valid & byte_ready;
  // Right-shift assembly: after four bytes, byte k sits in bits [8k+7:8k].
  assign shifted_cnt = {byte_data, word_cnt[31:8]};
  assign shifted_sr  = {byte_data, word_sr[31:8]};
  assign words_inc   = words_loaded + 16'd1;
  assign wd_inc      = wd_cnt + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      byte_idx     <= 2'd0;
      word_cnt     <= 32'd0;
      word_sr      <= 32'd0;
      wd_cnt       <= 32'd0;
      words_loaded <= 16'd0;
    end else begin
      state        <= state_nx;
      byte_idx     <= byte_idx_nx;
      word_cnt     <= word_cnt_nx;
      word_sr      <= word_sr_nx;
      wd_cnt       <= wd_nx;
      words_loaded <= words_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    byte_idx_nx = byte_idx;
    word_cnt_nx = word_cnt;
    word_sr_nx  = word_sr;
    wd_nx       = wd_cnt;
    words_nx    = words_loaded;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_nx    = S_HDR;
          byte_idx_nx = 2'd0;
          word_cnt_nx = 32'd0;
          wd_nx       = 32'd0;
          words_nx    = 16'd0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          word_cnt_nx = shifted_cnt;
          byte_idx_nx = byte_idx + 2'd1;
          wd_nx       = 32'd0;
          if (byte_idx == 2'd3) begin
            if (shifted_cnt == 32'd0)         state_nx = S_DONE;
            else if (shifted_cnt > CAPACITY)  state_nx = S_ERR;
            else                              state_nx = S_DATA;
          end
        end else if (wd_inc >= TIMEOUT_W) begin
          state_nx = S_ERR;
        end else begin
          wd_nx = wd_inc;
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_sr_nx  = shifted_sr;
          byte_idx_nx = byte_idx + 2'd1;
          wd_nx       = 32'd0;
          if (byte_idx == 2'd3) state_nx = S_WRITE;
        end else if (wd_inc >= TIMEOUT_W) begin
          state_nx = S_ERR;
        end else begin
          wd_nx = wd_inc;
        end
      end
      S_WRITE: begin
        words_nx = words_inc;
        state_nx = ({16'd0, words_inc} == word_cnt) ? S_DONE : S_DATA;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign byte_ready    = (state == S_HDR) || (state == S_DATA);
  assign busy          = (state == S_HDR) || (state == S_DATA) || (state == S_WRITE);
  assign done          = (state == S_DONE);
  assign error         = (state == S_ERR);
  assign core_hold     = (state != S_DONE);
  assign prog_en       = (state == S_WRITE);
  assign prog_addr     = prog_en ? (XLEN'(BASE_ADDR) + (XLEN'(words_loaded) << 2)) : '0;
  assign prog_data     = prog_en ? XLEN'(word_sr) : '0;
  assign fetch_ren_out = fetch_ren_in & ~core_hold;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        prog_en;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        fetch_ren_in = 1'b0;
  logic        fetch_ren_out;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int base;

  imem_loader #(.XLEN(32), .ROM_SIZE(8192), .BASE_ADDR(0), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .prog_en(prog_en), .prog_addr(prog_addr), .prog_data(prog_data),
    .fetch_ren_in(fetch_ren_in), .fetch_ren_out(fetch_ren_out),
    .core_hold(core_hold), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (prog_en) begin
      wr_addr.push_back(prog_addr);
      wr_data.push_back(prog_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int cyc = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    if (!byte_ready) check("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
    else tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
    $fatal(1);
  end

  initial begin
    // Reset values
    fetch_ren_in = 1'b1;
    tick();
    tick();
    check("rst_core_hold", {31'd0, core_hold}, 32'd1);
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_prog_en", {31'd0, prog_en}, 32'd0);
    check("rst_prog_addr", prog_addr, 32'd0);
    check("rst_prog_data", prog_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_words", {16'd0, words_loaded}, 32'd0);
    check("rst_fetch_gate", {31'd0, fetch_ren_out}, 32'd0);
    reset = 1'b0;
    tick();

    // Two-word load
    pulse_start();
    check("ld_busy", {31'd0, busy}, 32'd1);
    check("ld_ready", {31'd0, byte_ready}, 32'd1);
    send_word(32'd2);
    send_word(32'h2021000A);
    send_word(32'h44600040);
    check("ld_prog_en", {31'd0, prog_en}, 32'd1);
    check("ld_addr1_live", prog_addr, 32'h4);
    check("ld_data1_live", prog_data, 32'h44600040);
    check("ld_not_done_yet", {31'd0, done}, 32'd0);
    tick();
    check("ld_done", {31'd0, done}, 32'd1);
    check("ld_hold", {31'd0, core_hold}, 32'd0);
    check("ld_words", {16'd0, words_loaded}, 32'd2);
    check("ld_addr_idle", prog_addr, 32'd0);
    check("ld_data_idle", prog_data, 32'd0);
    check("ld_nwrites", wr_addr.size(), 32'd2);
    check("ld_addr0", wr_addr[0], 32'h0);
    check("ld_data0", wr_data[0], 32'h2021000A);
    check("ld_addr1", wr_addr[1], 32'h4);
    check("ld_data1", wr_data[1], 32'h44600040);
    check("ld_fetch_on", {31'd0, fetch_ren_out}, 32'd1);
    fetch_ren_in = 1'b0;
    #1;
    check("ld_fetch_off", {31'd0, fetch_ren_out}, 32'd0);
    fetch_ren_in = 1'b1;

    // Oversized header: N = 2049
    base = wr_addr.size();
    pulse_start();
    check("big_done_clr", {31'd0, done}, 32'd0);
    send_word(32'd2049);
    check("big_error", {31'd0, error}, 32'd1);
    check("big_hold", {31'd0, core_hold}, 32'd1);
    check("big_fetch", {31'd0, fetch_ren_out}, 32'd0);
    tick();
    tick();
    check("big_nwrites", wr_addr.size() - base, 32'd0);
    check("big_error_sticky", {31'd0, error}, 32'd1);
    pulse_start();
    check("big_error_clr", {31'd0, error}, 32'd0);
    check("big_restart_busy", {31'd0, busy}, 32'd1);

    // Watchdog: 16 idle cycles after two data bytes
    send_word(32'd2);
    send_word(32'h44332211);
    send_byte(8'h55);
    send_byte(8'h66);
    for (int i = 0; i < 15; i++) tick();
    check("wd_not_yet", {31'd0, error}, 32'd0);
    tick();
    check("wd_error", {31'd0, error}, 32'd1);
    check("wd_words", {16'd0, words_loaded}, 32'd1);

    // Reset during third WRITE of a five-word load
    pulse_start();
    send_word(32'd5);
    base = wr_addr.size();
    send_word(32'hA0A0A0A0);
    send_word(32'hB1B1B1B1);
    send_word(32'hC2C2C2C2);
    check("rw_prog_en", {31'd0, prog_en}, 32'd1);
    check("rw_addr", prog_addr, 32'h8);
    reset = 1'b1;
    #1;
    check("rw_prog_en_clr", {31'd0, prog_en}, 32'd0);
    check("rw_words_clr", {16'd0, words_loaded}, 32'd0);
    check("rw_busy_clr", {31'd0, busy}, 32'd0);
    check("rw_hold", {31'd0, core_hold}, 32'd1);
    tick();
    reset = 1'b0;
    check("rw_nwrites", wr_addr.size() - base, 32'd2);
    tick();

    // Start with a byte in IDLE: the byte must not enter the header
    start = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'hFF;
    tick();
    start = 1'b0;
    byte_valid = 1'b0;
    base = wr_addr.size();
    send_word(32'd0);
    check("n0_done", {31'd0, done}, 32'd1);
    check("n0_hold", {31'd0, core_hold}, 32'd0);
    check("n0_words", {16'd0, words_loaded}, 32'd0);
    check("n0_nwrites", wr_addr.size() - base, 32'd0);

    // N=1 with start pulses during DATA
    pulse_start();
    send_word(32'd1);
    send_byte(8'hAA);
    pulse_start();
    check("ign_busy", {31'd0, busy}, 32'd1);
    send_byte(8'hBB);
    pulse_start();
    send_byte(8'hCC);
    send_byte(8'hDD);
    check("ign_prog_en", {31'd0, prog_en}, 32'd1);
    check("ign_addr", prog_addr, 32'h0);
    check("ign_data", prog_data, 32'hDDCCBBAA);
    tick();
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_words", {16'd0, words_loaded}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
